// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst and response encodings, address-channel
// payload, and the state encoding of the burst master FSM.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Address-channel payload shared by AW and AR
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_ax_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_RSP
  } mst_state_e;

endpackage

// File: rtl/axi_beat_buf.sv
// Line buffer of BEAT beats of DW bits.
// Ports: clk/rst_n; load_en/load_line load a whole line; beat_we/beat_idx/
// beat_wdata write one beat; rd_idx/rd_data read one beat (combinational mux);
// line is the registered line contents.
module axi_beat_buf #(
  parameter int unsigned DW   = 64,
  parameter int unsigned BEAT = 4,
  parameter int unsigned CW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [DW*BEAT-1:0] load_line,
  input  logic               beat_we,
  input  logic [CW-1:0]      beat_idx,
  input  logic [DW-1:0]      beat_wdata,
  input  logic [CW-1:0]      rd_idx,
  output logic [DW-1:0]      rd_data,
  output logic [DW*BEAT-1:0] line
);

  logic [DW*BEAT-1:0] line_q;
  logic [DW*BEAT-1:0] line_d;

  // Whole-line load takes priority over a single-beat update
  always_comb begin
    line_d = line_q;
    if (load_en) begin
      line_d = load_line;
    end else if (beat_we) begin
      line_d[32'(beat_idx) * DW +: DW] = beat_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign rd_data = line_q[32'(rd_idx) * DW +: DW];
  assign line    = line_q;

endmodule

// File: rtl/axi_full_mst_burst.sv
// AXI4 master issuing one line-sized INCR burst (read or write) per client
// request, returning the line on reads and a one-cycle completion/error pulse.
// Ports: CLK/RSTn; client req_* (valid/ready/wr/addr/wdata); rsp_* completion;
// MEM_AW*/W*/B*/AR*/R* AXI4 master channels.
module axi_full_mst_burst
  import axi_pkg::*;
#(
  parameter int unsigned DW   = 64,
  parameter int unsigned BEAT = 4,
  parameter logic [7:0]  ID   = 8'd0
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wr,
  input  logic [31:0]        req_addr,
  input  logic [DW*BEAT-1:0] req_wdata,
  output logic               rsp_valid,
  output logic [DW*BEAT-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic [7:0]         MEM_AWID,
  output logic [31:0]        MEM_AWADDR,
  output logic [7:0]         MEM_AWLEN,
  output logic [2:0]         MEM_AWSIZE,
  output logic [1:0]         MEM_AWBURST,
  output logic               MEM_AWVALID,
  input  logic               MEM_AWREADY,
  output logic [DW-1:0]      MEM_WDATA,
  output logic [DW/8-1:0]    MEM_WSTRB,
  output logic               MEM_WLAST,
  output logic               MEM_WVALID,
  input  logic               MEM_WREADY,
  input  logic [7:0]         MEM_BID,
  input  logic [1:0]         MEM_BRESP,
  input  logic               MEM_BVALID,
  output logic               MEM_BREADY,
  output logic [7:0]         MEM_ARID,
  output logic [31:0]        MEM_ARADDR,
  output logic [7:0]         MEM_ARLEN,
  output logic [2:0]         MEM_ARSIZE,
  output logic [1:0]         MEM_ARBURST,
  output logic               MEM_ARVALID,
  input  logic               MEM_ARREADY,
  input  logic [7:0]         MEM_RID,
  input  logic [DW-1:0]      MEM_RDATA,
  input  logic [1:0]         MEM_RRESP,
  input  logic               MEM_RLAST,
  input  logic               MEM_RVALID,
  output logic               MEM_RREADY
);

  localparam int unsigned   LW        = DW * BEAT;
  localparam int unsigned   CW        = (BEAT > 1) ? $clog2(BEAT) : 1;
  localparam int unsigned   SZ        = $clog2(DW / 8);
  localparam int unsigned   OFFB      = $clog2(LW / 8);
  localparam logic [31:0]   ADDR_MASK = ~((32'd1 << OFFB) - 32'd1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BEAT - 1);
  localparam axi_ax_t       AX_RST    = '{id: ID, addr: 32'd0, len: 8'(BEAT - 1),
                                          size: 3'(SZ), burst: AXI_BURST_INCR};

  mst_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  axi_ax_t       ax_q, ax_d;

  logic          req_ready_q, req_ready_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          wlast_q, wlast_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;

  logic          load_en;
  logic          beat_we;
  logic [DW-1:0] buf_rd_data;
  logic [LW-1:0] buf_line;

  // Single outstanding transaction, so response IDs carry no information
  logic unused_id_c;
  assign unused_id_c = ^{MEM_BID, MEM_RID};

  // Write path reads beat cnt_d so WDATA is registered alongside WVALID
  axi_beat_buf #(.DW(DW), .BEAT(BEAT), .CW(CW)) u_buf (
    .clk       (CLK),
    .rst_n     (RSTn),
    .load_en   (load_en),
    .load_line (req_wdata),
    .beat_we   (beat_we),
    .beat_idx  (cnt_q),
    .beat_wdata(MEM_RDATA),
    .rd_idx    (cnt_d),
    .rd_data   (buf_rd_data),
    .line      (buf_line)
  );

  // Next-state, beat counter and sticky error
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ax_d    = ax_q;
    load_en = 1'b0;
    beat_we = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          ax_d.addr = req_addr & ADDR_MASK;
          load_en   = 1'b1;
          state_d   = req_wr ? ST_AW : ST_AR;
        end
      end
      ST_AW: if (MEM_AWREADY) state_d = ST_W;
      ST_W: begin
        if (MEM_WREADY) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_B: begin
        if (MEM_BVALID) begin
          err_d   = err_q | (MEM_BRESP != AXI_RESP_OKAY);
          state_d = ST_RSP;
        end
      end
      ST_AR: if (MEM_ARREADY) state_d = ST_R;
      ST_R: begin
        if (MEM_RVALID) begin
          beat_we = 1'b1;
          err_d   = err_q | (MEM_RRESP != AXI_RESP_OKAY);
          if (cnt_q == CNT_LAST) begin
            err_d   = err_d | ~MEM_RLAST;
            cnt_d   = '0;
            state_d = ST_RSP;
          end else begin
            err_d = err_d | MEM_RLAST;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_RSP: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state will present
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    awvalid_d   = (state_d == ST_AW);
    wvalid_d    = (state_d == ST_W);
    wlast_d     = (state_d == ST_W) && (cnt_d == CNT_LAST);
    wdata_d     = buf_rd_data;
    bready_d    = (state_d == ST_B);
    arvalid_d   = (state_d == ST_AR);
    rready_d    = (state_d == ST_R);
    rsp_valid_d = (state_d == ST_RSP);
    rsp_err_d   = (state_d == ST_RSP) && err_d;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ax_q        <= AX_RST;
      req_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      wdata_q     <= '0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ax_q        <= ax_d;
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      wdata_q     <= wdata_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = buf_line;

  assign MEM_AWID    = ax_q.id;
  assign MEM_AWADDR  = ax_q.addr;
  assign MEM_AWLEN   = ax_q.len;
  assign MEM_AWSIZE  = ax_q.size;
  assign MEM_AWBURST = ax_q.burst;
  assign MEM_AWVALID = awvalid_q;

  assign MEM_WDATA   = wdata_q;
  assign MEM_WSTRB   = {(DW/8){1'b1}};
  assign MEM_WLAST   = wlast_q;
  assign MEM_WVALID  = wvalid_q;
  assign MEM_BREADY  = bready_q;

  assign MEM_ARID    = ax_q.id;
  assign MEM_ARADDR  = ax_q.addr;
  assign MEM_ARLEN   = ax_q.len;
  assign MEM_ARSIZE  = ax_q.size;
  assign MEM_ARBURST = ax_q.burst;
  assign MEM_ARVALID = arvalid_q;
  assign MEM_RREADY  = rready_q;

endmodule
